// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO controller driving a two-port RAM (port A write, port B read)
module fifo_ctrl #(
  parameter int AW           = 3,
  parameter int DW           = 4,
  parameter int ALMOST_FULL  = 6,
  parameter int ALMOST_EMPTY = 1
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          push,
  input  logic [DW-1:0] data_in,
  input  logic          pop,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  output logic [AW-1:0] mem_addr_a,
  output logic          mem_rw_a,
  output logic [DW-1:0] mem_din_a,
  output logic [AW-1:0] mem_addr_b,
  output logic          mem_rw_b,
  input  logic [DW-1:0] mem_dout_b
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);
  localparam logic [AW:0] AF_TH = (AW+1)'(ALMOST_FULL);
  localparam logic [AW:0] AE_TH = (AW+1)'(ALMOST_EMPTY);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        valid_q, valid_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic        push_ok, pop_ok;

  // Extra wrap bit lets count reach DEPTH without ambiguity against empty.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign mem_addr_a = wr_ptr_q[AW-1:0];
  assign mem_rw_a   = push_ok;
  assign mem_din_a  = data_in;
  assign mem_addr_b = rd_ptr_q[AW-1:0];
  assign mem_rw_b   = 1'b0;

  // The RAM registers port B every edge, so its output lines up with valid_q.
  assign data_out  = mem_dout_b;
  assign valid_out = valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    valid_d     = pop_ok;
    overflow_d  = overflow_q | (push & full);
    underflow_d = underflow_q | (pop & empty);
    if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - self-checking bench for fifo_ctrl with a behavioural RAM beside it
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       push = 1'b0, pop = 1'b0;
  logic [3:0] data_in = '0;
  logic [3:0] data_out;
  logic       valid_out, full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;
  logic [2:0] mem_addr_a, mem_addr_b;
  logic       mem_rw_a, mem_rw_b;
  logic [3:0] mem_din_a, mem_dout_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.AW(3), .DW(4), .ALMOST_FULL(6), .ALMOST_EMPTY(1)) dut (
    .clk(clk), .reset_L(reset_L), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow),
    .mem_addr_a(mem_addr_a), .mem_rw_a(mem_rw_a), .mem_din_a(mem_din_a),
    .mem_addr_b(mem_addr_b), .mem_rw_b(mem_rw_b), .mem_dout_b(mem_dout_b)
  );

  // Behavioural two-port RAM: synchronous write on A, registered read on B.
  logic [3:0] ram [8];
  always @(posedge clk) begin
    if (mem_rw_a) ram[mem_addr_a] <= mem_din_a;
    mem_dout_b <= ram[mem_addr_b];
  end

  // Reference model state.
  int         m_count = 0;
  logic [3:0] m_wr = '0, m_rd = '0;
  logic       m_ovf = 1'b0, m_udf = 1'b0, m_valid = 1'b0;
  logic [3:0] fifo_q[$];
  logic [3:0] sb_q[$];

  typedef struct {
    logic       p;
    logic       o;
    logic [3:0] d;
    int         cnt;
    logic       vld;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_wr = '0; m_rd = '0;
    m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0;
    fifo_q.delete(); sb_q.delete();
  endtask

  task automatic check_status();
    chk("count", int'(count), m_count);
    chk("full", int'(full), int'(m_count == 8));
    chk("empty", int'(empty), int'(m_count == 0));
    chk("almost_full", int'(almost_full), int'(m_count >= 6));
    chk("almost_empty", int'(almost_empty), int'(m_count <= 1));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_udf));
    chk("valid_out", int'(valid_out), int'(m_valid));
    chk("mem_rw_b", int'(mem_rw_b), 0);
  endtask

  // One clock: drive inputs, check port-A/B controls, clock, update model, check outputs.
  task automatic cyc(input logic p, input logic o, input logic [3:0] d);
    logic pok, ook;
    push = p; pop = o; data_in = d;
    pok = p && (m_count != 8);
    ook = o && (m_count != 0);
    #1;
    chk("mem_rw_a", int'(mem_rw_a), int'(pok));
    chk("mem_addr_a", int'(mem_addr_a), int'(m_wr[2:0]));
    chk("mem_addr_b", int'(mem_addr_b), int'(m_rd[2:0]));
    if (pok) chk("mem_din_a", int'(mem_din_a), int'(d));
    if (p && !pok) m_ovf = 1'b1;
    if (o && !ook) m_udf = 1'b1;
    if (ook) begin
      sb_q.push_back(fifo_q.pop_front());
      m_rd = m_rd + 4'd1;
      m_count--;
    end
    if (pok) begin
      fifo_q.push_back(d);
      m_wr = m_wr + 4'd1;
      m_count++;
    end
    m_valid = ook;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
    check_status();
    if (valid_out && sb_q.size() > 0) chk("data_out", int'(data_out), int'(sb_q.pop_front()));
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_status();
    chk("rst_mem_rw_a", int'(mem_rw_a), 0);
    reset_L = 1'b1;

    // Fill, overflow, drain, underflow, empty push+pop, refill, full push+pop.
    for (int i = 0; i < 8; i++) vecs.push_back('{1'b1, 1'b0, 4'(i + 1), i + 1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'hF, 8, 1'b0});
    for (int i = 0; i < 8; i++) vecs.push_back('{1'b0, 1'b1, 4'h0, 7 - i, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'hA, 1, 1'b0});
    for (int i = 0; i < 7; i++) vecs.push_back('{1'b1, 1'b0, 4'(i + 3), i + 2, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'hE, 7, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 7, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].p, vecs[i].o, vecs[i].d);
      chk("vec_count", int'(count), vecs[i].cnt);
      chk("vec_valid", int'(valid_out), int'(vecs[i].vld));
    end
    chk("sticky_ovf", int'(overflow), 1);
    chk("sticky_udf", int'(underflow), 1);

    // Reset clears sticky flags.
    reset_L = 1'b0;
    #1;
    model_reset();
    check_status();
    @(posedge clk);
    #1;
    reset_L = 1'b1;

    // Simultaneous push+pop at count 4 across pointer wrap.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'(i + 1));
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 4'($urandom_range(0, 15)));
      chk("steady_count", int'(count), 4);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 4'h0);
    cyc(1'b0, 1'b0, 4'h0);

    // Reset with count 5 and a pop in flight.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 4'(i + 7));
    cyc(1'b0, 1'b1, 4'h0);
    chk("inflight_valid", int'(valid_out), 1);
    chk("inflight_count", int'(count), 5);
    reset_L = 1'b0;
    #1;
    model_reset();
    chk("reset_valid_drop", int'(valid_out), 0);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    check_status();
    chk("post_reset_count", int'(count), 0);
    chk("post_reset_empty", int'(empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control-side initiator for the two-port `Memoria` RAM: drives port A as the write port and port B as the read port, turning the raw RAM into a synchronous FIFO. It owns the read/write pointers, occupancy count, status flags and error flags. Clients see a push/pop interface; the RAM instance sits beside this block and is wired only to the `mem_*` ports.

## Interface
Parameters:
- `AW`, 3: RAM address width; FIFO depth is 2^AW.
- `DW`, 4: data width.
- `ALMOST_FULL`, 6: `almost_full` asserts when count >= this value.
- `ALMOST_EMPTY`, 1: `almost_empty` asserts when count <= this value.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `push`  in  1  write request.
- `data_in`  in  DW  write data, sampled with `push`.
- `pop`  in  1  read request.
- `data_out`  out  DW  read data, valid while `valid_out`=1.
- `valid_out`  out  1  registered; high the cycle after an accepted pop.
- `full`, `empty`  out  1  occupancy flags.
- `almost_full`, `almost_empty`  out  1  threshold flags.
- `count`  out  AW+1  occupancy, 0..2^AW.
- `overflow`, `underflow`  out  1  sticky error flags.
- `mem_addr_a`  out  AW  RAM port A address.
- `mem_rw_a`  out  1  RAM port A mode (1 = write).
- `mem_din_a`  out  DW  RAM port A write data.
- `mem_addr_b`  out  AW  RAM port B address.
- `mem_rw_b`  out  1  RAM port B mode; constant 0.
- `mem_dout_b`  in  DW  RAM port B registered read data.

## Operation
- State: `wr_ptr` and `rd_ptr`, each AW+1 bits. The MSB is the wrap bit.
- `count` = `wr_ptr` − `rd_ptr`, computed modulo 2^(AW+1).
- `full` = (count == 2^AW). `empty` = (count == 0). All four status flags are combinational from `count`.
- Push acceptance: `push_ok` = `push` & ~`full`.
  - When accepted: `mem_rw_a`=1, `mem_addr_a`=`wr_ptr[AW-1:0]`, `mem_din_a`=`data_in`; `wr_ptr` increments at the edge.
  - Otherwise: `mem_rw_a`=0 and `mem_addr_a`=`wr_ptr[AW-1:0]`.
- Pop acceptance: `pop_ok` = `pop` & ~`empty`.
  - `mem_addr_b`=`rd_ptr[AW-1:0]` at all times.
  - When accepted, `rd_ptr` increments at the edge and `valid_out` is set for the next cycle.
- `data_out` = `mem_dout_b` (pass-through). It is meaningful only while `valid_out`=1.
- Simultaneous push and pop:
  - Both are evaluated against the pre-edge `count`.
  - When neither flag blocks, both are accepted and `count` is unchanged.
  - When full, the pop is accepted and the push is rejected.
  - When empty, the push is accepted and the pop is rejected. No fall-through.
- Address hazard: accepted push and pop never share an address. The push address equals `rd_ptr` only when empty or full, and in both cases one side is rejected.
- Errors:
  - `push` while `full` sets `overflow`.
  - `pop` while `empty` sets `underflow`.
  - Both flags stay set until reset. Rejected requests change no pointer.
- Wrap-around: pointers roll over naturally at 2^(AW+1). The address wraps at 2^AW.

## Timing
- Reset (async assert, deassert synchronous to `clk` externally):
  - `wr_ptr`=`rd_ptr`=0, `valid_out`=0, `overflow`=`underflow`=0.
  - Therefore `count`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `mem_rw_a`=0.
  - RAM contents are not cleared.
- Reset mid-operation: all in-flight state is discarded and `valid_out` drops immediately.
- Write latency: data pushed at edge N is poppable from cycle N+1.
- Read latency: pop accepted at edge N → `valid_out`=1 with correct `data_out` during cycle N+1.
- Back-to-back pops yield one word per cycle. `valid_out` deasserts the cycle after the last accepted pop.
- Flags and `count` reflect the post-edge pointers in the same cycle.

## Test plan
- Reset then fill: push 0x1..0x8, one per cycle (AW=3, DW=4).
  - `count` steps 1..8.
  - `almost_full` at count 6.
  - `full`=1 after the 8th push.
  - No `overflow`.
- Drain: pop 8 times back-to-back. `data_out` sequence is 0x1..0x8 on consecutive `valid_out` cycles. Then `empty`=1 and `almost_empty`=1.
- Overflow/underflow:
  - Push while full → `overflow`=1 and `count` stays 8.
  - After draining, pop while empty → `underflow`=1 and `valid_out` stays 0.
  - Both flags hold until `reset_L`=0.
- Simultaneous push+pop at count 4 for 10 cycles:
  - `count` stays 4.
  - Output order matches input order.
  - Pointers wrap past address 7 without data corruption.
- Edge cases:
  - Push+pop while empty → only the push is taken; `count`=1, `valid_out`=0.
  - Push+pop while full → only the pop is taken; `count`=7, `valid_out`=1 next cycle.
- Reset with count=5 and a pop in flight → `valid_out`=0 immediately; `count`=0 and `empty`=1 after deassert.
